// File: rtl/big_adder.sv
// Pipelined unsigned adder: out = in1 + zero-extended in2.
// One SLICE-bit adder per stage, linked by registered carries.
module big_adder #(
    parameter int W1    = 16,
    parameter int W2    = 8,
    parameter int SLICE = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W1-1:0] in1,
    input  logic [W2-1:0] in2,
    output logic [W1:0]   out
);

    localparam int NSTAGE = W1 / SLICE;

    logic [W1-1:0] w_bx;

    assign w_bx = W1'(in2);

    for (genvar j = 0; j < NSTAGE; j++) begin : g_slc
        logic [SLICE-1:0]       w_a;
        logic [SLICE-1:0]       w_b;
        logic                   w_ci;
        logic [SLICE:0]         w_add;
        logic                   r_cy;
        logic [(j+1)*SLICE-1:0] r_sum;

        assign w_add = {1'b0, w_a} + {1'b0, w_b} + {{SLICE{1'b0}}, w_ci};

        always_ff @(posedge clock) begin
            if (reset) begin
                r_cy <= 1'b0;
            end else begin
                r_cy <= w_add[SLICE];
            end
        end

        if (j == 0) begin : g_first
            assign w_a  = in1[SLICE-1:0];
            assign w_b  = w_bx[SLICE-1:0];
            assign w_ci = 1'b0;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_sum <= '0;
                end else begin
                    r_sum <= w_add[SLICE-1:0];
                end
            end
        end else begin : g_rest
            // Slice j waits j edges so it meets the carry from slice j-1
            logic [SLICE-1:0] r_ad [j];
            logic [SLICE-1:0] r_bd [j];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < j; i++) begin
                        r_ad[i] <= '0;
                        r_bd[i] <= '0;
                    end
                    r_sum <= '0;
                end else begin
                    r_ad[0] <= in1[j*SLICE +: SLICE];
                    r_bd[0] <= w_bx[j*SLICE +: SLICE];
                    for (int i = 1; i < j; i++) begin
                        r_ad[i] <= r_ad[i-1];
                        r_bd[i] <= r_bd[i-1];
                    end
                    r_sum <= {w_add[SLICE-1:0], g_slc[j-1].r_sum};
                end
            end

            assign w_a  = r_ad[j-1];
            assign w_b  = r_bd[j-1];
            assign w_ci = g_slc[j-1].r_cy;
        end
    end

    assign out = {g_slc[NSTAGE-1].r_cy, g_slc[NSTAGE-1].r_sum};

endmodule

// File: tb/tb_big_adder.sv
// Directed bench for big_adder (default 16+8 bit, two stages).
// Inputs change and outputs are checked on the falling edge.
module tb_big_adder;

    logic        clock;
    logic        reset;
    logic [15:0] in1;
    logic [7:0]  in2;
    logic [16:0] out;

    int total = 0;
    int bad   = 0;

    big_adder #(.W1(16), .W2(8), .SLICE(8)) dut (
        .clock(clock),
        .reset(reset),
        .in1  (in1),
        .in2  (in2),
        .out  (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input logic r, input logic [15:0] a,
                        input logic [7:0] b);
        reset = r;
        in1   = a;
        in2   = b;
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [16:0] exp);
        total++;
        assert (out === exp)
        else begin
            bad++;
            $error("FAIL %s: out=%h expected=%h", tag, out, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        in1   = '0;
        in2   = '0;
        @(negedge clock);

        step(1'b1, 16'h0000, 8'h00);
        check("reset_edge1", 17'h00000);
        step(1'b1, 16'h0000, 8'h00);
        check("reset_edge2", 17'h00000);

        // Each step shows the sum of the pair given one step earlier
        step(1'b0, 16'hFFFF, 8'h00);
        check("latency_still_zero", 17'h00000);
        step(1'b0, 16'hFFFF, 8'h01);
        check("ffff_plus_00", 17'h0FFFF);
        step(1'b0, 16'h0000, 8'h01);
        check("ffff_plus_01", 17'h10000);
        step(1'b0, 16'h0000, 8'h00);
        check("0000_plus_01", 17'h00001);
        step(1'b0, 16'hFFFF, 8'hFF);
        check("0000_plus_00", 17'h00000);
        step(1'b0, 16'h00FF, 8'h01);
        check("max_operands", 17'h100FE);
        step(1'b0, 16'hFFFF, 8'h01);
        check("inter_stage_carry", 17'h00100);

        // Reset while (FFFF,01) is in flight; the pair given with reset is lost
        step(1'b1, 16'h1234, 8'h56);
        check("reset_flush", 17'h00000);
        step(1'b0, 16'h1234, 8'h56);
        check("after_reset_empty", 17'h00000);
        step(1'b0, 16'h7F80, 8'h80);
        check("1234_plus_56", 17'h0128A);
        step(1'b0, 16'h0000, 8'h00);
        check("7f80_plus_80", 17'h08000);
        step(1'b0, 16'h0000, 8'h00);
        check("zero_tail", 17'h00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
